// File: rtl/calc_operand_sequencer.sv
// Serial front-end for the combinational calculator: collects A, B, op,
// drives {op,B,A}, waits LAT cycles, then holds the result for a consumer.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   entry handshake, in_data carries A, B or opcode
//   calc_word           packed calculator input {op, B, A}
//   calc_out            combinational calculator result
//   res_valid/res_ready result handshake, res_data holds the capture
//   busy                high while issuing or holding a result
//   clr                 entry abort, only with CALC_SEQ_CLR_EN defined
module calc_operand_sequencer #(
  parameter int OPW = 3,
  parameter int OPC = 2,
  parameter int RW  = 8,
  parameter int LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPW-1:0]         in_data,
  output logic [2*OPW+OPC-1:0]   calc_word,
  input  logic [RW-1:0]          calc_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RW-1:0]          res_data,
  output logic                   busy
`ifdef CALC_SEQ_CLR_EN
  ,
  input  logic                   clr
`endif
);

  localparam int CWW = 2 * OPW + OPC;
  localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

  typedef enum logic [2:0] {
    S_GET_A  = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_ISSUE  = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  a_q, a_d;
  logic [OPW-1:0]  b_q, b_d;
  logic [OPC-1:0]  op_q, op_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [CWW-1:0]  word_q, word_d;
  logic [RW-1:0]   res_q, res_d;
  logic            rv_q, rv_d;

  logic            clr_w;
  logic            entry_st;
  logic            acc;

`ifdef CALC_SEQ_CLR_EN
  assign clr_w = clr;
`else
  assign clr_w = 1'b0;
`endif

  assign entry_st = (state_q == S_GET_A) ||
                    (state_q == S_GET_B) ||
                    (state_q == S_GET_OP);

  // clr wins over a same-cycle entry, so it blocks acceptance
  assign acc = in_valid & entry_st & ~clr_w;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    res_d   = res_q;
    rv_d    = rv_q;

    if (clr_w && entry_st) begin
      state_d = S_GET_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else begin
      unique case (state_q)
        S_GET_A: begin
          if (acc) begin
            a_d     = in_data;
            state_d = S_GET_B;
          end
        end
        S_GET_B: begin
          if (acc) begin
            b_d     = in_data;
            state_d = S_GET_OP;
          end
        end
        S_GET_OP: begin
          if (acc) begin
            op_d    = in_data[OPC-1:0];
            word_d  = {in_data[OPC-1:0], b_q, a_q};
            cnt_d   = '0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cnt_q == CNT_LAST) begin
            res_d   = calc_out;
            rv_d    = 1'b1;
            cnt_d   = '0;
            state_d = S_RESULT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_RESULT: begin
          if (rv_q && res_ready) begin
            rv_d    = 1'b0;
            state_d = S_GET_A;
          end
        end
        default: begin
          state_d = S_GET_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
    end
  end

  assign in_ready  = entry_st;
  assign busy      = (state_q == S_ISSUE) || (state_q == S_RESULT);
  assign calc_word = word_q;
  assign res_valid = rv_q;
  assign res_data  = res_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Bench for calc_operand_sequencer: LAT=1 instance with calc model
// word+1, LAT=4 instance with a bench-driven calc_out sequence.
module tb_calc_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;

  logic       iv1 = 1'b0, ir1, rv1, rr1 = 1'b1, busy1;
  logic [2:0] id1 = '0;
  logic [7:0] cw1, co1, rd1;

  logic       iv4 = 1'b0, ir4, rv4, rr4 = 1'b1, busy4;
  logic [2:0] id4 = '0;
  logic [7:0] cw4, rd4;
  logic [7:0] co4 = '0;

  int checks = 0;
  int fails  = 0;
  logic [7:0] q1[$];
  logic [7:0] q4[$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  assign co1 = cw1 + 8'd1;

  calc_operand_sequencer #(.OPW(3), .OPC(2), .RW(8), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .calc_word(cw1), .calc_out(co1),
    .res_valid(rv1), .res_ready(rr1), .res_data(rd1),
    .busy(busy1)
`ifdef CALC_SEQ_CLR_EN
    , .clr(clr)
`endif
  );

  calc_operand_sequencer #(.OPW(3), .OPC(2), .RW(8), .LAT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .calc_word(cw4), .calc_out(co4),
    .res_valid(rv4), .res_ready(rr4), .res_data(rd4),
    .busy(busy4)
`ifdef CALC_SEQ_CLR_EN
    , .clr(clr)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [2:0] v);
    iv1 = 1'b1;
    id1 = v;
    for (int i = 0; i < 20; i++) begin
      if (ir1) break;
      cyc();
    end
    cyc();
    iv1 = 1'b0;
  endtask

  task automatic send4(input logic [2:0] v);
    iv4 = 1'b1;
    id4 = v;
    for (int i = 0; i < 20; i++) begin
      if (ir4) break;
      cyc();
    end
    cyc();
    iv4 = 1'b0;
  endtask

  task automatic wait_rv1(input int maxc, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n <= maxc) begin
      if (rv1) begin
        ok = 1'b1;
        break;
      end
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    checks++;
    if ({ir1, cw1, rv1, rd1, busy1} !== {1'b1, 8'h00, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset1 got ir=%b cw=%h rv=%b rd=%h busy=%b want 1 00 0 00 0",
               ir1, cw1, rv1, rd1, busy1);
    end
    checks++;
    if ({ir4, cw4, rv4, rd4, busy4} !== {1'b1, 8'h00, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset4 got ir=%b cw=%h rv=%b rd=%h busy=%b want 1 00 0 00 0",
               ir4, cw4, rv4, rd4, busy4);
    end
  endtask

  task automatic test_basic();
    rr1 = 1'b1;
    send1(3'd3);
    send1(3'd2);
    send1(3'd1);
    q1.push_back(8'h54);
    checks++;
    if (cw1 !== 8'h53 || busy1 !== 1'b1 || ir1 !== 1'b0 || rv1 !== 1'b0) begin
      fails++;
      $display("FAIL basic_t1 got cw=%h busy=%b ir=%b rv=%b want 53 1 0 0",
               cw1, busy1, ir1, rv1);
    end
    cyc();
    checks++;
    if (rv1 !== 1'b1) begin
      fails++;
      $display("FAIL basic_t2_valid got %b want 1", rv1);
    end else begin
      exp_v = q1.pop_front();
      checks++;
      if (rd1 !== exp_v) begin
        fails++;
        $display("FAIL basic_data got %h want %h", rd1, exp_v);
      end
    end
    cyc();
    checks++;
    if (rv1 !== 1'b0 || ir1 !== 1'b1) begin
      fails++;
      $display("FAIL basic_t3 got rv=%b ir=%b want 0 1", rv1, ir1);
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit ok;
    rr1 = 1'b0;
    send1(3'd1);
    send1(3'd2);
    send1(3'd2);
    q1.push_back(8'h92);
    wait_rv1(10, n, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_wait got timeout want res_valid");
    end else begin
      exp_v = q1.pop_front();
      for (int i = 0; i < 5; i++) begin
        iv1 = i[0];
        id1 = 3'd7;
        cyc();
        checks++;
        if (rv1 !== 1'b1 || rd1 !== exp_v || ir1 !== 1'b0) begin
          fails++;
          $display("FAIL bp_hold%0d got rv=%b rd=%h ir=%b want 1 %h 0",
                   i, rv1, rd1, ir1, exp_v);
        end
      end
      iv1 = 1'b0;
      rr1 = 1'b1;
      cyc();
      checks++;
      if (rv1 !== 1'b0 || ir1 !== 1'b1 || rd1 !== exp_v) begin
        fails++;
        $display("FAIL bp_release got rv=%b ir=%b rd=%h want 0 1 %h",
                 rv1, ir1, rd1, exp_v);
      end
    end
    send1(3'd4);
    send1(3'd1);
    checks++;
    if (cw1 !== 8'h91) begin
      fails++;
      $display("FAIL bp_partial_word got %h want 91", cw1);
    end
    send1(3'd0);
    q1.push_back(8'h0d);
    checks++;
    if (cw1 !== 8'h0c) begin
      fails++;
      $display("FAIL bp_fresh_word got %h want 0c", cw1);
    end
    wait_rv1(10, n, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL bp_fresh_wait got timeout want res_valid");
    end else begin
      exp_v = q1.pop_front();
      checks++;
      if (rd1 !== exp_v) begin
        fails++;
        $display("FAIL bp_fresh_data got %h want %h", rd1, exp_v);
      end
    end
    cyc();
  endtask

  task automatic test_gapped();
    int n;
    bit ok;
    send1(3'd7);
    for (int i = 0; i < 3; i++) cyc();
    send1(3'd0);
    checks++;
    if (cw1 !== 8'h0c || ir1 !== 1'b1) begin
      fails++;
      $display("FAIL gap_hold got cw=%h ir=%b want 0c 1", cw1, ir1);
    end
    send1(3'd3);
    q1.push_back(8'hc8);
    checks++;
    if (cw1 !== 8'hc7) begin
      fails++;
      $display("FAIL gap_word got %h want c7", cw1);
    end
    wait_rv1(10, n, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL gap_wait got timeout want res_valid");
    end else begin
      exp_v = q1.pop_front();
      checks++;
      if (rd1 !== exp_v) begin
        fails++;
        $display("FAIL gap_data got %h want %h", rd1, exp_v);
      end
    end
    cyc();
  endtask

  task automatic test_lat4();
    rr4 = 1'b1;
    co4 = 8'h00;
    send4(3'd2);
    send4(3'd5);
    send4(3'd1);
    checks++;
    if (cw4 !== 8'h6a) begin
      fails++;
      $display("FAIL lat4_word got %h want 6a", cw4);
    end
    for (int k = 1; k <= 4; k++) begin
      co4 = 8'ha0 + 8'(k);
      if (k == 4) q4.push_back(co4);
      checks++;
      if (rv4 !== 1'b0 || busy4 !== 1'b1) begin
        fails++;
        $display("FAIL lat4_early%0d got rv=%b busy=%b want 0 1", k, rv4, busy4);
      end
      cyc();
    end
    co4 = 8'h55;
    checks++;
    if (rv4 !== 1'b1) begin
      fails++;
      $display("FAIL lat4_valid got %b want 1", rv4);
    end else begin
      exp_v = q4.pop_front();
      checks++;
      if (rd4 !== exp_v) begin
        fails++;
        $display("FAIL lat4_data got %h want %h", rd4, exp_v);
      end
    end
    cyc();
    checks++;
    if (rv4 !== 1'b0 || ir4 !== 1'b1) begin
      fails++;
      $display("FAIL lat4_done got rv=%b ir=%b want 0 1", rv4, ir4);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    logic [2:0] a, b, o;
    rr1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      o = 3'($urandom_range(0, 7));
      send1(a);
      send1(b);
      send1(o);
      q1.push_back({o[1:0], b, a} + 8'd1);
      checks++;
      if (cw1 !== {o[1:0], b, a}) begin
        fails++;
        $display("FAIL b2b_word%0d got %h want %h", i, cw1, {o[1:0], b, a});
      end
      wait_rv1(10, n, ok);
      checks++;
      if (!ok || n != 1) begin
        fails++;
        $display("FAIL b2b_lat%0d got ok=%b wait=%0d want 1 1", i, ok, n);
      end
      if (ok) begin
        exp_v = q1.pop_front();
        checks++;
        if (rd1 !== exp_v) begin
          fails++;
          $display("FAIL b2b_data%0d got %h want %h", i, rd1, exp_v);
        end
      end
      cyc();
      checks++;
      if (ir1 !== 1'b1 || rv1 !== 1'b0) begin
        fails++;
        $display("FAIL b2b_ret%0d got ir=%b rv=%b want 1 0", i, ir1, rv1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    rr4 = 1'b1;
    send4(3'd2);
    send4(3'd5);
    send4(3'd1);
    co4 = 8'h77;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({ir4, cw4, rv4, rd4, busy4} !== {1'b1, 8'h00, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL rst_issue got ir=%b cw=%h rv=%b rd=%h busy=%b want 1 00 0 00 0",
               ir4, cw4, rv4, rd4, busy4);
    end
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (rv4 !== 1'b0 || rd4 !== 8'h00) begin
      fails++;
      $display("FAIL rst_issue_discard got rv=%b rd=%h want 0 00", rv4, rd4);
    end
    rr1 = 1'b0;
    send1(3'd3);
    send1(3'd2);
    send1(3'd1);
    q1.push_back(8'h54);
    wait_rv1(10, n, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL rst_res_wait got timeout want res_valid");
    end else begin
      exp_v = q1.pop_front();
      checks++;
      if (rd1 !== exp_v) begin
        fails++;
        $display("FAIL rst_res_data got %h want %h", rd1, exp_v);
      end
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rr1 = 1'b1;
    checks++;
    if ({ir1, cw1, rv1, rd1, busy1} !== {1'b1, 8'h00, 1'b0, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL rst_result got ir=%b cw=%h rv=%b rd=%h busy=%b want 1 00 0 00 0",
               ir1, cw1, rv1, rd1, busy1);
    end
  endtask

`ifdef CALC_SEQ_CLR_EN
  task automatic test_clr();
    int n;
    bit ok;
    rr1 = 1'b1;
    send1(3'd5);
    send1(3'd6);
    clr = 1'b1;
    iv1 = 1'b1;
    id1 = 3'd2;
    cyc();
    clr = 1'b0;
    iv1 = 1'b0;
    checks++;
    if (ir1 !== 1'b1 || busy1 !== 1'b0 || cw1 !== 8'h00) begin
      fails++;
      $display("FAIL clr_abort got ir=%b busy=%b cw=%h want 1 0 00", ir1, busy1, cw1);
    end
    send1(3'd1);
    send1(3'd1);
    send1(3'd0);
    q1.push_back(8'h0a);
    checks++;
    if (cw1 !== 8'h09) begin
      fails++;
      $display("FAIL clr_word got %h want 09", cw1);
    end
    wait_rv1(10, n, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL clr_wait got timeout want res_valid");
    end else begin
      exp_v = q1.pop_front();
      checks++;
      if (rd1 !== exp_v) begin
        fails++;
        $display("FAIL clr_data got %h want %h", rd1, exp_v);
      end
    end
    cyc();
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_lat4();
    test_back_to_back();
    test_reset_mid();
`ifdef CALC_SEQ_CLR_EN
    test_clr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
